// File: rtl/square_seq_pkg.sv
// Shared widths and control encodings for the bit-serial squarer and square-root units.
package square_seq_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // One spare bit above 2*width so a sum of two full-scale squares fits.
  function automatic int sqr_out_width(input int bit_width);
    return 2 * bit_width + 1;
  endfunction

  function automatic int sqr_cnt_width(input int bit_width);
    return $clog2(bit_width);
  endfunction

endpackage

// File: rtl/square_seq.sv
// Shift-add squarer: one multiplier bit per cycle, fixed BIT_WIDTH-cycle latency.
// Define SQR_ACCUM_EN to seed the accumulator from x_out when accum is sampled high.
module square_seq
  import square_seq_pkg::*;
#(
  parameter int BIT_WIDTH = 12,
  localparam int OUT_WIDTH = sqr_out_width(BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic                 start,
  input  logic                 accum,
  output logic [OUT_WIDTH-1:0] x_out,
  output logic                 finish
);

  localparam int CNT_W = sqr_cnt_width(BIT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIT_WIDTH - 1);

  logic [0:0]           state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [BIT_WIDTH-1:0] a_q, a_d;
  logic [OUT_WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [OUT_WIDTH-1:0] x_out_q, x_out_d;
  logic [OUT_WIDTH-1:0] step_sum;

`ifndef SQR_ACCUM_EN
  logic unused_accum;
  assign unused_accum = accum;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    m_d      = m_q;
    count_d  = count_q;
    x_out_d  = x_out_q;
    step_sum = a_q[0] ? (acc_q + m_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = x_in;
          m_d     = OUT_WIDTH'(x_in);
          count_d = '0;
          acc_d   = '0;
`ifdef SQR_ACCUM_EN
          if (accum) begin
            acc_d = x_out_q;
          end
`endif
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d   = step_sum;
        a_d     = a_q >> 1;
        m_d     = m_q << 1;
        count_d = count_q + CNT_W'(1);
        // The final step's add must land in x_out on the same edge.
        if (count_q == LAST_COUNT) begin
          x_out_d = step_sum;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      x_out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      m_q     <= m_d;
      count_q <= count_d;
      x_out_q <= x_out_d;
    end
  end

  assign x_out  = x_out_q;
  assign finish = (state_q == S_IDLE);

endmodule

// File: doc/square_seq.md
Name: square_seq

Overview:
- Sequential bit-by-bit (shift-add) squarer; the inverse of the team's bit-serial square-root unit, with the same start/finish handshake.
- Computes x_in² one multiplier bit per cycle at fixed latency.
- Sits ahead of the square-root unit in the distance/shading datapath. With the optional accumulate feature it produces x²+y², which feeds sqrt for radial distance.

Parameters:
- BIT_WIDTH, 12, operand width in bits; must be at least 2.
- OUT_WIDTH, 2*BIT_WIDTH+1 (derived localparam, not overridable), result width; one extra bit holds a sum of two squares.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- x_in  input  BIT_WIDTH  unsigned operand; sampled only on an accepted start.
- start  input  1  request; accepted only while finish=1.
- accum  input  1  sampled with start; add the new square to the held result (SQR_ACCUM_EN only, ignored otherwise).
- x_out  output  OUT_WIDTH  result register; stable except on the completion edge.
- finish  output  1  idle/done flag; 1 = result valid and ready for a new start.

Behaviour:
- Reset (synchronous, clk edge with reset=1): finish=1, x_out=0, internal acc/a/m/count=0. Any operation in flight is aborted and no partial result reaches x_out.
- States: IDLE (finish=1) and BUSY (finish=0); finish is the registered IDLE indicator.
- IDLE, start=1:
  - a<=x_in; m<=zero-extended x_in to OUT_WIDTH; count<=0.
  - acc<=0, or acc<=x_out when SQR_ACCUM_EN and accum=1.
  - Go to BUSY.
- IDLE, start=0: hold all state.
- BUSY, each cycle:
  - If a[0]=1 then acc<=acc+m (OUT_WIDTH-bit add, wraps modulo 2^OUT_WIDTH).
  - a<=a>>1; m<=m<<1 (bits beyond OUT_WIDTH dropped); count<=count+1.
- BUSY, count=BIT_WIDTH-1:
  - x_out<=final acc, including this cycle's add.
  - finish<=1; go to IDLE.
- Latency: start sampled at edge T gives finish=0 from T. finish=1 and the valid x_out both appear at edge T+BIT_WIDTH (12 cycles for the default).
- Throughput: one op per BIT_WIDTH+1 cycles. A start held high through completion is accepted on the first edge where finish=1 is already registered.
- No early termination; latency is fixed regardless of operand (x_in=0 still takes BIT_WIDTH cycles).
- start while BUSY: ignored, no queueing; x_in and accum are don't-care.
- x_out holds its previous result throughout BUSY and updates only on the completion edge.
- Without SQR_ACCUM_EN the x_out MSB is always 0, because (2^BIT_WIDTH-1)² < 2^(2*BIT_WIDTH).
- count width is clog2(BIT_WIDTH). No combinational path from inputs to outputs.

Optional Feature:
- Macro SQR_ACCUM_EN.
- Defined: when accum=1 is sampled with an accepted start, acc is seeded from the current x_out, so the result is x_out_prev + x_in². Two consecutive ops give x²+y² ≤ 2*(2^BIT_WIDTH-1)², which fits OUT_WIDTH. Sums beyond that wrap modulo 2^OUT_WIDTH; there is no saturation.
- Undefined: the accum port stays present but is unused, and acc is always seeded with 0.

Decomposition:
- Shared package: the OUT_WIDTH derivation (2*BIT_WIDTH+1), the counter-width function (clog2), and the state encoding constants (S_IDLE, S_BUSY), shared with the sqrt unit's control.
- No sub-module required. The single shift-add step (acc, a, m) stays inline; splitting out a step module adds ports without reuse.

Test Plan (BIT_WIDTH=12):
- Reset then idle → finish=1 and x_out=0. x_in=3, start pulse at edge T → finish=0 from T, finish=1 at T+12, x_out=9, and x_out stays 0 during busy.
- x_in=4095 → x_out=16769025; x_in=0 → x_out=0 with the same 12-cycle latency. x_in=2048 → x_out=4194304.
- Start with x_in=5, then pulse start with x_in=7 at cycle 4 of busy → the second start is ignored and the result is 25. start held high continuously → ops complete every 13 cycles.
- Start with x_in=100, assert reset at cycle 6 → finish=1 and x_out=0 on the next edge. A following op with x_in=10 → 100.
- SQR_ACCUM_EN: op x_in=3 accum=0 → 9, then x_in=4 accum=1 → 25; x_in=4095 accum=0, then x_in=4095 accum=1 → 33538050 (x_out MSB=1). Macro undefined, same sequence → 9, 16 (accum ignored).
